// File: rtl/dsr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dsr_ctrl_pkg
// Shared types and constants for the dynamic shift register loopback
// controller: FSM state encoding, default register depth and the tap-select
// width helper.
// ----------------------------------------------------------------------------
package dsr_ctrl_pkg;

   localparam int unsigned DSR_DEPTH_DEFAULT = 8;

   // ST_FLUSH is only reachable when DSR_FLUSH_EN is defined
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SWEEP = 3'd2,
      ST_DONE  = 3'd3,
      ST_FLUSH = 3'd4
   } dsr_state_e;

   // Tap-select width for a register of 'depth' bits (never below 1)
   function automatic int unsigned sel_width(input int unsigned depth);
      if (depth <= 2) begin
         return 1;
      end
      return $clog2(depth);
   endfunction

endpackage : dsr_ctrl_pkg

// File: rtl/dynamic_shift_register.sv
// ----------------------------------------------------------------------------
// dynamic_shift_register
// Serial-in shift register with a selectable tap. Shifts towards the MSB when
// clken is high; DO presents data[SEL] combinationally.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (clears the contents)
//   clken  in   shift enable
//   SI     in   serial input, enters at bit 0
//   SEL    in   tap select
//   DO     out  data[SEL]
// ----------------------------------------------------------------------------
module dynamic_shift_register #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   input  logic             SI,
   input  logic [SEL_W-1:0] SEL,
   output logic             DO
);

   logic [DEPTH-1:0] data_q;
   logic [DEPTH-1:0] data_d;

   // Next contents: shift one place when enabled
   always_comb begin
      data_d = data_q;
      if (clken) begin
         data_d = {data_q[DEPTH-2:0], SI};
      end
   end

   // Storage
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign DO = data_q[SEL];

endmodule : dynamic_shift_register

// File: rtl/dsr_loopback_ctrl.sv
// ----------------------------------------------------------------------------
// dsr_loopback_ctrl
// Sequencer that uses a dynamic_shift_register as a self-checked serial store.
// A request word is shifted in MSB first (write mode), then every tap is
// swept and captured into a readback word, returned with a mismatch flag.
//
// Optional feature macro: DSR_FLUSH_EN
//   When defined, the readback handshake is followed by DEPTH cycles of
//   shifting zeros so the register is left cleared before the next request.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-low reset
//   in_valid    in   request valid
//   in_ready    out  controller idle; accept on in_valid & in_ready
//   in_data     in   word to load
//   in_rd_only  in   1 = skip the load, read current contents only
//   out_valid   out  readback valid
//   out_ready   in   consumer accepts readback
//   out_data    out  captured taps, out_data[k] = DO with SEL = k
//   out_err     out  write mode: readback differs from the loaded word
//   sr_clken    out  register shift enable
//   sr_si       out  register serial input
//   sr_sel      out  register tap select
//   sr_do       in   register tapped output
// ----------------------------------------------------------------------------
module dsr_loopback_ctrl
   import dsr_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = DSR_DEPTH_DEFAULT,
   parameter int unsigned SEL_W = sel_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DEPTH-1:0] in_data,
   input  logic             in_rd_only,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DEPTH-1:0] out_data,
   output logic             out_err,
   output logic             sr_clken,
   output logic             sr_si,
   output logic [SEL_W-1:0] sr_sel,
   input  logic             sr_do
);

   dsr_state_e       state_q,     state_d;
   logic [SEL_W-1:0] cnt_q,       cnt_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [DEPTH-1:0] out_data_q,  out_data_d;
   logic             out_err_q,   out_err_d;
   logic             sr_clken_q,  sr_clken_d;
   logic             sr_si_q,     sr_si_d;
   logic [SEL_W-1:0] sr_sel_q,    sr_sel_d;
   logic [DEPTH-1:0] ref_word_q,  ref_word_d;
   logic             rd_only_q,   rd_only_d;
   logic [DEPTH-1:0] cap_q,       cap_d;

   logic             cnt_last;
   logic [DEPTH-1:0] cap_upd;

   assign cnt_last = (cnt_q == SEL_W'(DEPTH - 1));

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      sr_clken_d  = 1'b0;
      sr_si_d     = 1'b0;
      sr_sel_d    = sr_sel_q;
      ref_word_d  = ref_word_q;
      rd_only_d   = rd_only_q;
      cap_d       = cap_q;

      // Capture word including the tap being presented this cycle
      cap_upd        = cap_q;
      cap_upd[cnt_q] = sr_do;

      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               ref_word_d = in_data;
               rd_only_d  = in_rd_only;
               in_ready_d = 1'b0;
               cnt_d      = '0;
               sr_sel_d   = '0;
               if (in_rd_only) begin
                  state_d = ST_SWEEP;
               end else begin
                  // First LOAD cycle already presents the MSB
                  state_d    = ST_LOAD;
                  sr_clken_d = 1'b1;
                  sr_si_d    = in_data[DEPTH-1];
               end
            end
         end

         ST_LOAD: begin
            if (cnt_last) begin
               state_d  = ST_SWEEP;
               cnt_d    = '0;
               sr_sel_d = '0;
            end else begin
               // Bit for the next cycle: ref[DEPTH-1-(cnt+1)]
               cnt_d      = cnt_q + SEL_W'(1);
               sr_clken_d = 1'b1;
               sr_si_d    = ref_word_q[SEL_W'(DEPTH - 2) - cnt_q];
            end
         end

         ST_SWEEP: begin
            cap_d = cap_upd;
            if (cnt_last) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               sr_sel_d    = '0;
               out_data_d  = cap_upd;
               out_valid_d = 1'b1;
               out_err_d   = !rd_only_q && (cap_upd != ref_word_q);
            end else begin
               cnt_d    = cnt_q + SEL_W'(1);
               sr_sel_d = cnt_q + SEL_W'(1);
            end
         end

         ST_DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
`ifdef DSR_FLUSH_EN
               state_d     = ST_FLUSH;
               sr_clken_d  = 1'b1;
`else
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
`endif
            end
         end

`ifdef DSR_FLUSH_EN
         ST_FLUSH: begin
            // Shift zeros for DEPTH cycles; sr_si stays at its default of 0
            if (cnt_last) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               in_ready_d = 1'b1;
            end else begin
               cnt_d      = cnt_q + SEL_W'(1);
               sr_clken_d = 1'b1;
            end
         end
`endif

         default: begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            in_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         sr_clken_q  <= 1'b0;
         sr_si_q     <= 1'b0;
         sr_sel_q    <= '0;
         ref_word_q  <= '0;
         rd_only_q   <= 1'b0;
         cap_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         sr_clken_q  <= sr_clken_d;
         sr_si_q     <= sr_si_d;
         sr_sel_q    <= sr_sel_d;
         ref_word_q  <= ref_word_d;
         rd_only_q   <= rd_only_d;
         cap_q       <= cap_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign sr_clken  = sr_clken_q;
   assign sr_si     = sr_si_q;
   assign sr_sel    = sr_sel_q;

endmodule : dsr_loopback_ctrl

// File: tb/tb_dsr_loopback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dsr_loopback_ctrl
// Controller plus a shift register instance. Table of requests with expected
// readback, latency and shift activity; expected readbacks go through a
// scoreboard queue popped on the output handshake. Hand-written sequences
// cover back-pressure, mid-load reset and (with DSR_FLUSH_EN) the flush.
// ----------------------------------------------------------------------------
module tb_dsr_loopback_ctrl;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned SEL_W = 3;

   typedef struct {
      logic       rd;
      logic [7:0] data;
      logic       f0;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       err;
   } sb_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [DEPTH-1:0] in_data;
   logic             in_rd_only;
   logic             out_valid;
   logic             out_ready;
   logic [DEPTH-1:0] out_data;
   logic             out_err;
   logic             sr_clken;
   logic             sr_si;
   logic [SEL_W-1:0] sr_sel;
   logic             sr_do;
   logic             reg_do;
   logic             sr_rst;
   logic             force0;

   int errors = 0;
   int checks = 0;
   sb_t sb_q[$];

   always #5 clk = ~clk;

   assign sr_rst = !rst;
   assign sr_do  = force0 ? 1'b0 : reg_do;

   dsr_loopback_ctrl #(.DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_rd_only (in_rd_only),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_err    (out_err),
      .sr_clken   (sr_clken),
      .sr_si      (sr_si),
      .sr_sel     (sr_sel),
      .sr_do      (sr_do)
   );

   dynamic_shift_register #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sr (
      .clk   (clk),
      .rst   (sr_rst),
      .clken (sr_clken),
      .SI    (sr_si),
      .SEL   (sr_sel),
      .DO    (reg_do)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
   endtask

   // Scoreboard: pop on the cycle before the handshake edge
   always @(negedge clk) begin
      sb_t e;
      if (rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            fail_now("sb_underflow");
         end else begin
            e = sb_q.pop_front();
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_txn(input logic rd, input logic [7:0] data, input logic f0,
                         input logic [7:0] exp_d, input logic exp_e,
                         input int exp_lat, input int stall);
      int         n;
      int         ck;
      logic [7:0] si_w;
      logic       si_or;
      bit         ok;
      sb_t        e;

      wait_ready(ok);
      if (!ok) begin
         fail_now("ready_timeout");
         return;
      end
      force0     = f0;
      out_ready  = (stall == 0);
      in_valid   = 1'b1;
      in_data    = data;
      in_rd_only = rd;
      @(posedge clk);
      e.data = exp_d;
      e.err  = exp_e;
      sb_q.push_back(e);
      #1;
      in_valid = 1'b0;

      ck = 0; si_w = '0; n = 0; ok = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         if (sr_clken) begin
            ck++;
            si_w = {si_w[6:0], sr_si};
         end
         @(posedge clk); #1;
         if (out_valid) begin
            n  = i;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("out_timeout");
         force0 = 1'b0;
         return;
      end
      check("latency", 32'(n), 32'(exp_lat));
      check("clken_cycles", 32'(ck), rd ? 32'd0 : 32'd8);
      if (!rd) check("si_seq", 32'(si_w), 32'(data));

      // Back-pressure: outputs hold, a new request is not taken
      if (stall > 0) begin
         in_valid   = 1'b1;
         in_data    = 8'h55;
         in_rd_only = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(exp_d));
            check("stall_err", 32'(out_err), 32'(exp_e));
            check("stall_in_ready", 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end

      @(posedge clk); #1;   // handshake edge
      check("hs_valid_drop", 32'(out_valid), 32'd0);
`ifdef DSR_FLUSH_EN
      ck = 0; si_or = 1'b0; n = 0; ok = 1'b0;
      for (int i = 0; i <= 100; i++) begin
         if (in_ready) begin
            n  = i;
            ok = 1'b1;
            break;
         end
         if (sr_clken) begin
            ck++;
            si_or = si_or | sr_si;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         fail_now("flush_timeout");
      end else begin
         check("flush_ready_lat", 32'(n), 32'd8);
         check("flush_clken", 32'(ck), 32'd8);
         check("flush_si", 32'(si_or), 32'd0);
      end
`else
      si_or = 1'b0;
      check("hs_ready", 32'(in_ready), 32'd1);
      check("hs_clken", 32'(sr_clken | si_or), 32'd0);
`endif
      force0 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      bit   ok;

`ifdef DSR_FLUSH_EN
      localparam logic [7:0] RB_B2 = 8'h00;
      localparam logic [7:0] RB_5A = 8'h00;
`else
      localparam logic [7:0] RB_B2 = 8'hB2;
      localparam logic [7:0] RB_5A = 8'h5A;
`endif

      //           rd    data   f0    exp_d  err   lat
      vecs[0] = '{1'b0, 8'hB2, 1'b0, 8'hB2, 1'b0, 16};
      vecs[1] = '{1'b1, 8'h00, 1'b0, RB_B2, 1'b0, 8};
      vecs[2] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 16};
      vecs[3] = '{1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 16};
      vecs[4] = '{1'b1, 8'hFF, 1'b0, RB_5A, 1'b0, 8};
      vecs[5] = '{1'b0, 8'h01, 1'b1, 8'h00, 1'b1, 16};
      vecs[6] = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 16};
      vecs[7] = '{1'b1, 8'h80, 1'b1, 8'h00, 1'b0, 8};

      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_rd_only = 1'b0;
      out_ready  = 1'b1;
      force0     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_clken", 32'(sr_clken), 32'd0);
      check("rst_si", 32'(sr_si), 32'd0);
      check("rst_sel", 32'(sr_sel), 32'd0);
      rst = 1'b1;

      for (int v = 0; v < 8; v++) begin
         do_txn(vecs[v].rd, vecs[v].data, vecs[v].f0,
                vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat, 0);
      end

      // Back-pressure for 5 cycles with a competing request, then 8'h55
      do_txn(1'b0, 8'hC3, 1'b0, 8'hC3, 1'b0, 16, 5);
      do_txn(1'b0, 8'h55, 1'b0, 8'h55, 1'b0, 16, 0);

      // Reset during the 4th LOAD cycle
      wait_ready(ok);
      if (!ok) begin
         fail_now("rst_seq_ready");
      end else begin
         in_valid   = 1'b1;
         in_data    = 8'h9E;
         in_rd_only = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("mid_load_clken", 32'(sr_clken), 32'd1);
         rst = 1'b0;
         @(posedge clk); #1;
         rst = 1'b1;
         check("mid_rst_in_ready", 32'(in_ready), 32'd1);
         check("mid_rst_clken", 32'(sr_clken), 32'd0);
         check("mid_rst_valid", 32'(out_valid), 32'd0);
         check("mid_rst_sel", 32'(sr_sel), 32'd0);
         do_txn(1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 16, 0);
      end

`ifdef DSR_FLUSH_EN
      do_txn(1'b0, 8'hA7, 1'b0, 8'hA7, 1'b0, 16, 0);
      do_txn(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8, 0);
`else
      do_txn(1'b1, 8'h00, 1'b0, 8'h3C, 1'b0, 8, 0);
`endif

      repeat (4) @(posedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dsr_loopback_ctrl
